// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array drain path
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    DRAIN,
    CLEAR,
    DONE
  } drain_state_t;

  // Index width that stays at least one bit even for degenerate sizes
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_out_reg.sv
// rtl/systolic_out_reg.sv - load-enabled output register holding one result and its last flag
module systolic_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d_msg,
  input  logic         d_last,
  output logic [W-1:0] msg,
  output logic         last
);

  logic [W:0] data_q;
  logic [W:0] data_d;

  // Capture a new (last, msg) pair only on load; otherwise hold through stalls
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = {d_last, d_msg};
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msg  = data_q[W-1:0];
  assign last = data_q[W];

endmodule

// File: rtl/systolic_drain_ctrl.sv
// rtl/systolic_drain_ctrl.sv - serialises the SIZE x SIZE accumulator results onto a val/rdy stream
module systolic_drain_ctrl
  import systolic_pkg::*;
#(
  parameter  int SIZE   = 4,
  parameter  int DATA_W = 32,
  localparam int IW_R   = idx_w(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drain_req,
  output logic [IW_R-1:0]        acc_row_sel,
  input  logic [SIZE*DATA_W-1:0] acc_row_data,
  output logic                   send_val,
  input  logic                   send_rdy,
  output logic [DATA_W-1:0]      send_msg,
  output logic                   send_last,
  output logic                   acc_clr,
  output logic                   busy,
  output logic                   done
);

  localparam int              N        = SIZE * SIZE;
  localparam int              IW_S     = idx_w(N);
  localparam logic [IW_R-1:0] RC_LAST  = IW_R'(SIZE - 1);
  localparam logic [IW_S-1:0] IDX_LAST = IW_S'(N - 1);

  drain_state_t    state_q, state_d;
  logic [IW_R-1:0] f_row_q, f_row_d;
  logic [IW_R-1:0] f_col_q, f_col_d;
  logic [IW_S-1:0] idx_q, idx_d;
  logic            send_val_q, send_val_d;
  logic            acc_clr_q, acc_clr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic              load;
  logic [DATA_W-1:0] col_data;
  logic              ld_last;
  logic [IW_R-1:0]   nxt_row;
  logic [IW_R-1:0]   nxt_col;

  // Column mux over the currently selected row, plus the row-major successor of the fetch pointer
  always_comb begin
    col_data = '0;
    for (int c = 0; c < SIZE; c++) begin
      if (f_col_q == IW_R'(c)) begin
        col_data = acc_row_data[c*DATA_W +: DATA_W];
      end
    end
    ld_last = (f_row_q == RC_LAST) && (f_col_q == RC_LAST);
    if (f_col_q == RC_LAST) begin
      nxt_col = '0;
      nxt_row = (f_row_q == RC_LAST) ? '0 : f_row_q + 1'b1;
    end else begin
      nxt_col = f_col_q + 1'b1;
      nxt_row = f_row_q;
    end
  end

  // Next-state, counter and output decode; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    f_row_d = f_row_q;
    f_col_d = f_col_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain_req) begin
          state_d = PRIME;
          f_row_d = '0;
          f_col_d = '0;
          idx_d   = '0;
        end
      end
      PRIME: begin
        load    = 1'b1;
        f_row_d = nxt_row;
        f_col_d = nxt_col;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (send_val_q && send_rdy) begin
          if (idx_q == IDX_LAST) begin
            state_d = CLEAR;
          end else begin
            load    = 1'b1;
            f_row_d = nxt_row;
            f_col_d = nxt_col;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = DONE;
      end
      DONE: begin
        // Wait for the request to drop so a stale level cannot start a second drain
        if (!drain_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    send_val_d = (state_d == DRAIN);
    acc_clr_d  = (state_d == CLEAR);
    busy_d     = (state_d == PRIME) || (state_d == DRAIN) || (state_d == CLEAR);
    done_d     = (state_d == DONE);
  end

  // FSM state, fetch pointer, send index and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      f_row_q    <= '0;
      f_col_q    <= '0;
      idx_q      <= '0;
      send_val_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_row_q    <= f_row_d;
      f_col_q    <= f_col_d;
      idx_q      <= idx_d;
      send_val_q <= send_val_d;
      acc_clr_q  <= acc_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  systolic_out_reg #(
    .W(DATA_W)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d_msg (col_data),
    .d_last(ld_last),
    .msg   (send_msg),
    .last  (send_last)
  );

  assign acc_row_sel = f_row_q;
  assign send_val    = send_val_q;
  assign acc_clr     = acc_clr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// tb/tb_systolic_drain_ctrl.sv - self-checking bench for systolic_drain_ctrl
module tb_systolic_drain_ctrl;

  localparam int SIZE = 2;
  localparam int DW   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             drain_req;
  logic [0:0]       acc_row_sel;
  logic [SIZE*DW-1:0] acc_row_data;
  logic             send_val;
  logic             send_rdy;
  logic [DW-1:0]    send_msg;
  logic             send_last;
  logic             acc_clr;
  logic             busy;
  logic             done;

  logic [DW-1:0] mat [SIZE][SIZE];
  bit            bp_pat [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Accumulator array model: combinational row read
  always_comb begin
    acc_row_data = '0;
    for (int c = 0; c < SIZE; c++) begin
      acc_row_data[c*DW +: DW] = mat[int'(acc_row_sel)][c];
    end
  end

  systolic_drain_ctrl #(
    .SIZE  (SIZE),
    .DATA_W(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .drain_req   (drain_req),
    .acc_row_sel (acc_row_sel),
    .acc_row_data(acc_row_data),
    .send_val    (send_val),
    .send_rdy    (send_rdy),
    .send_msg    (send_msg),
    .send_last   (send_last),
    .acc_clr     (acc_clr),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit next_rdy(input int mode, input int pos);
    if (mode == 0) return 1'b1;
    if (mode == 1) return bp_pat[pos % 8];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fill_fixed();
    mat[0][0] = 8'h11; mat[0][1] = 8'h22;
    mat[1][0] = 8'h33; mat[1][1] = 8'h44;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        mat[r][c] = DW'($urandom);
  endtask

  // rdy_mode: 0 always ready, 1 fixed backpressure pattern, 2 random
  // req_mode: 0 pulse, 1 hold through DONE, 2 drop after first handshake
  // abort_after: >0 asserts reset after that many handshakes
  task automatic do_drain(input int rdy_mode, input int req_mode, input int abort_after);
    logic [DW-1:0] exp_q[$];
    int edges, sent, budget, pos;
    exp_q = {};
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        exp_q.push_back(mat[r][c]);

    chk("idle_val", send_val, 0);
    chk("idle_busy", busy, 0);
    drain_req = 1'b1;
    send_rdy  = 1'b0;
    tick();
    edges = 1;
    if (req_mode == 0) drain_req = 1'b0;
    chk("prime_busy", busy, 1);
    chk("prime_val", send_val, 0);
    chk("prime_row_sel", acc_row_sel, 0);
    tick();
    edges++;

    pos = 0; sent = 0; budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      chk("drain_val", send_val, 1);
      chk("drain_msg", send_msg, exp_q[0]);
      chk("drain_last", send_last, exp_q.size() == 1);
      chk("drain_clr", acc_clr, 0);
      chk("drain_busy", busy, 1);
      if (abort_after > 0 && sent == abort_after) begin
        rst = 1'b0;
        #2;
        chk("rst_val", send_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr", acc_clr, 0);
        chk("rst_msg", send_msg, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_clr", acc_clr, 0);
        return;
      end
      send_rdy = next_rdy(rdy_mode, pos);
      pos++;
      tick();
      edges++;
      budget++;
      if (send_rdy) begin
        void'(exp_q.pop_front());
        sent++;
        if (req_mode == 2 && sent == 1) drain_req = 1'b0;
      end
    end
    chk("drain_timeout", budget < 200, 1);
    chk("sent_count", sent, SIZE*SIZE);

    send_rdy = 1'($urandom_range(0, 1));
    chk("clr_pulse", acc_clr, 1);
    chk("clr_val", send_val, 0);
    chk("clr_busy", busy, 1);
    chk("clr_done", done, 0);
    tick();
    edges++;
    chk("done_flag", done, 1);
    chk("done_clr", acc_clr, 0);
    chk("done_busy", busy, 0);
    if (rdy_mode == 0) chk("total_edges", edges, SIZE*SIZE + 3);

    if (req_mode == 1) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("held_done", done, 1);
        chk("held_val", send_val, 0);
        chk("held_busy", busy, 0);
      end
      drain_req = 1'b0;
    end
    tick();
    chk("back_idle_done", done, 0);
    chk("back_idle_busy", busy, 0);
    tick();
    chk("no_retrigger", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    drain_req = 1'b0;
    send_rdy  = 1'b0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        mat[r][c] = '0;
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("reset_val", send_val, 0);
    chk("reset_msg", send_msg, 0);
    chk("reset_last", send_last, 0);
    chk("reset_clr", acc_clr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_row_sel", acc_row_sel, 0);
    rst = 1'b1;
    tick();
    chk("idle_after_release", busy, 0);

    // Basic drain, no backpressure
    fill_fixed();
    do_drain(0, 0, 0);

    // Fixed backpressure pattern
    fill_rand();
    do_drain(1, 0, 0);

    // Held request, then a second drain with fresh data
    fill_rand();
    do_drain(2, 1, 0);
    fill_rand();
    do_drain(0, 0, 0);

    // Mid-drain reset, then a clean restart from the first element
    fill_fixed();
    do_drain(0, 0, 2);
    do_drain(0, 0, 0);

    // Request dropped during DRAIN
    fill_rand();
    do_drain(2, 2, 0);

    // Random traffic
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      do_drain(2, int'($urandom_range(0, 2)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
